// File: rtl/knight_rider_bounce.sv
// -----------------------------------------------------------------------------
// knight_rider_bounce
//
// Purpose:
//   Bouncing single-LED "scanner" across an 8-LED bar. A prescaler divides the
//   system clock into step ticks; on each tick the lit LED (the head) moves one
//   position. At each end the head dwells for PAUSE_STEPS extra step periods
//   before the sweep reverses.
//
// Parameters:
//   PRESCALE     clock cycles per LED step (1 .. 2^27-1)
//   PAUSE_STEPS  extra step periods the head dwells at each end (0 .. 15)
//
// Ports:
//   clk           in   system clock, rising edge
//   rstn          in   synchronous active-low reset
//   en            in   1 = prescaler and pattern advance, 0 = freeze
//   led_out       out  [7:0] LED drive, bit n = LED n (registered)
//   step_o        out  one-cycle pulse on every pattern-state update (registered)
//   turnaround_o  out  one-cycle pulse on the edge where the sweep reverses
//
// Build option:
//   KNIGHT_RIDER_TRAIL_EN  when defined, adds a dim (25% duty) trail LED one
//                          position behind the head during a sweep.
// -----------------------------------------------------------------------------
module knight_rider_bounce #(
    parameter int unsigned PRESCALE    = 12500000,
    parameter int unsigned PAUSE_STEPS = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    output logic [7:0] led_out,
    output logic       step_o,
    output logic       turnaround_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_DWELL_HI,
        S_DOWN,
        S_DWELL_LO
    } state_t;

    localparam logic [26:0] PRESC_LAST = 27'(PRESCALE - 1);
    localparam bit          HAS_DWELL  = (PAUSE_STEPS != 0);
    // Only meaningful when HAS_DWELL; kept legal for PAUSE_STEPS = 0.
    localparam logic [3:0]  DWELL_LAST = (PAUSE_STEPS == 0) ? 4'd0 : 4'(PAUSE_STEPS - 1);

    state_t      state_q, state_d;
    logic [2:0]  pos_q, pos_d;
    logic [3:0]  dcnt_q, dcnt_d;
    logic [26:0] presc_q, presc_d;
    logic [7:0]  led_q, led_d;
    logic        step_q, step_d;
    logic        turn_q, turn_d;
    logic        tick;

`ifdef KNIGHT_RIDER_TRAIL_EN
    logic [1:0]  pwm_q, pwm_d;
    // Set only after a step that stayed within the same sweep, so the first
    // step after IDLE or after a reversal shows no trail.
    logic        trail_ok_q, trail_ok_d;
`endif

    assign tick = en && (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dcnt_d  = dcnt_q;
        presc_d = presc_q;
        step_d  = tick;
        turn_d  = 1'b0;
        led_d   = 8'd0;

        if (en) begin
            presc_d = tick ? 27'd0 : presc_q + 27'd1;
        end

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_UP;
                    pos_d   = 3'd0;
                end
                S_UP: begin
                    if (pos_q != 3'd7) begin
                        pos_d = pos_q + 3'd1;
                    end else if (!HAS_DWELL) begin
                        state_d = S_DOWN;
                        pos_d   = 3'd6;
                        turn_d  = 1'b1;
                    end else begin
                        state_d = S_DWELL_HI;
                        dcnt_d  = 4'd0;
                    end
                end
                S_DWELL_HI: begin
                    if (dcnt_q == DWELL_LAST) begin
                        state_d = S_DOWN;
                        pos_d   = 3'd6;
                        turn_d  = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + 4'd1;
                    end
                end
                S_DOWN: begin
                    if (pos_q != 3'd0) begin
                        pos_d = pos_q - 3'd1;
                    end else if (!HAS_DWELL) begin
                        state_d = S_UP;
                        pos_d   = 3'd1;
                        turn_d  = 1'b1;
                    end else begin
                        state_d = S_DWELL_LO;
                        dcnt_d  = 4'd0;
                    end
                end
                S_DWELL_LO: begin
                    if (dcnt_q == DWELL_LAST) begin
                        state_d = S_UP;
                        pos_d   = 3'd1;
                        turn_d  = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    pos_d   = 3'd0;
                    dcnt_d  = 4'd0;
                end
            endcase
        end

        // LED image is built from next-state values so it lands on the same
        // edge as pos (no extra latency behind the tick).
        if (state_d != S_IDLE) begin
            led_d = 8'd1 << pos_d;
        end

`ifdef KNIGHT_RIDER_TRAIL_EN
        pwm_d      = pwm_q + 2'd1;
        trail_ok_d = trail_ok_q;
        if (tick) begin
            trail_ok_d = ((state_q == S_UP)   && (state_d == S_UP)) ||
                         ((state_q == S_DOWN) && (state_d == S_DOWN));
        end
        // Using pwm_d makes the trail visible in the cycles where pwm_q == 0.
        if (trail_ok_d && (pwm_d == 2'd0)) begin
            if (state_d == S_UP) begin
                led_d = led_d | (8'd1 << (pos_d - 3'd1));
            end else if (state_d == S_DOWN) begin
                led_d = led_d | (8'd1 << (pos_d + 3'd1));
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            pos_q   <= 3'd0;
            dcnt_q  <= 4'd0;
            presc_q <= 27'd0;
            led_q   <= 8'h00;
            step_q  <= 1'b0;
            turn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dcnt_q  <= dcnt_d;
            presc_q <= presc_d;
            led_q   <= led_d;
            step_q  <= step_d;
            turn_q  <= turn_d;
        end
    end

`ifdef KNIGHT_RIDER_TRAIL_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pwm_q      <= 2'd0;
            trail_ok_q <= 1'b0;
        end else begin
            pwm_q      <= pwm_d;
            trail_ok_q <= trail_ok_d;
        end
    end
`endif

    assign led_out      = led_q;
    assign step_o       = step_q;
    assign turnaround_o = turn_q;

endmodule

// File: tb/tb_knight_rider_bounce.sv
// -----------------------------------------------------------------------------
// tb_knight_rider_bounce
//
// Directed bench for knight_rider_bounce with PRESCALE=4. Instance A uses
// PAUSE_STEPS=2, instance B uses PAUSE_STEPS=0. Honours KNIGHT_RIDER_TRAIL_EN:
// with the trail built in, routine LED checks look only at the head bits and
// the pos=2 check expects the exact trail pattern.
// -----------------------------------------------------------------------------
module tb_knight_rider_bounce;

`ifdef KNIGHT_RIDER_TRAIL_EN
    localparam bit TRAIL = 1'b1;
`else
    localparam bit TRAIL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn_a, en_a, rstn_b, en_b;
    logic [7:0] led_a, led_b;
    logic       step_a, step_b, turn_a, turn_b;

    int cmp_cnt = 0;
    int err_cnt = 0;
    logic [7:0] cur_led;

    always #5 clk = ~clk;

    knight_rider_bounce #(.PRESCALE(4), .PAUSE_STEPS(2)) dut_a (
        .clk(clk), .rstn(rstn_a), .en(en_a),
        .led_out(led_a), .step_o(step_a), .turnaround_o(turn_a)
    );

    knight_rider_bounce #(.PRESCALE(4), .PAUSE_STEPS(0)) dut_b (
        .clk(clk), .rstn(rstn_b), .en(en_b),
        .led_out(led_b), .step_o(step_b), .turnaround_o(turn_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge, then compare outputs of the selected instance.
    task automatic edge_chk(input int sel, input logic [7:0] el, input logic es,
                            input logic et, input logic chk_s, input string tag);
        logic [7:0] l;
        logic s, t;
        @(posedge clk);
        #1;
        l = (sel != 0) ? led_b  : led_a;
        s = (sel != 0) ? step_b : step_a;
        t = (sel != 0) ? turn_b : turn_a;
        chk({tag, ".led"}, TRAIL ? (l & el) : l, el);
        if (chk_s) chk({tag, ".step"}, {7'd0, s}, {7'd0, es});
        chk({tag, ".turn"}, {7'd0, t}, {7'd0, et});
    endtask

    // One full step period: three quiet edges, then the step edge.
    task automatic step(input int sel, input logic [7:0] el, input logic et, input logic chk_s);
        for (int i = 0; i < 3; i++) edge_chk(sel, cur_led, 1'b0, 1'b0, 1'b1, "quiet");
        edge_chk(sel, el, 1'b1, et, chk_s, "step");
        cur_led = el;
        $display("step dut=%0d led=%h turn=%b", sel, el, et);
    endtask

    initial begin
        logic [7:0] up_seq [8];
        logic [7:0] t_exp;
        up_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        rstn_a = 1'b0; en_a = 1'b1;
        rstn_b = 1'b0; en_b = 1'b1;

        // Reset held 3 cycles with en=1: everything stays zero.
        for (int i = 0; i < 3; i++) edge_chk(0, 8'h00, 1'b0, 1'b0, 1'b1, "reset_hold");
        rstn_a  = 1'b1;
        cur_led = 8'h00;

        // Sweep up to 08; first step lands PRESCALE cycles after release.
        for (int i = 0; i < 4; i++) step(0, up_seq[i], 1'b0, 1'b1);

        // Freeze mid-count at 08, then resume the remaining count.
        edge_chk(0, 8'h08, 1'b0, 1'b0, 1'b1, "pre_freeze");
        edge_chk(0, 8'h08, 1'b0, 1'b0, 1'b1, "pre_freeze");
        en_a = 1'b0;
        for (int i = 0; i < 20; i++) edge_chk(0, 8'h08, 1'b0, 1'b0, 1'b1, "frozen");
        en_a = 1'b1;
        edge_chk(0, 8'h08, 1'b0, 1'b0, 1'b1, "resume_quiet");
        edge_chk(0, 8'h10, 1'b1, 1'b0, 1'b1, "resume_step");
        cur_led = 8'h10;
        $display("step dut=0 led=10 turn=0 (after freeze)");

        // Rest of the up sweep, dwell at top, reversal.
        for (int i = 5; i < 8; i++) step(0, up_seq[i], 1'b0, 1'b1);
        step(0, 8'h80, 1'b0, 1'b0);
        step(0, 8'h80, 1'b0, 1'b0);
        step(0, 8'h40, 1'b1, 1'b1);

        // Down sweep, dwell at bottom, reversal, and back up to the top.
        for (int i = 5; i >= 0; i--) step(0, up_seq[i], 1'b0, 1'b1);
        step(0, 8'h01, 1'b0, 1'b0);
        step(0, 8'h01, 1'b0, 1'b0);
        step(0, 8'h02, 1'b1, 1'b1);
        for (int i = 2; i < 8; i++) step(0, up_seq[i], 1'b0, 1'b1);
        step(0, 8'h80, 1'b0, 1'b0);
        step(0, 8'h80, 1'b0, 1'b0);
        step(0, 8'h40, 1'b1, 1'b1);
        step(0, 8'h20, 1'b0, 1'b1);
        step(0, 8'h10, 1'b0, 1'b1);

        // Reset in DOWN at 10, asserted just before a tick edge: reset wins.
        for (int i = 0; i < 3; i++) edge_chk(0, 8'h10, 1'b0, 1'b0, 1'b1, "pre_reset");
        rstn_a = 1'b0;
        edge_chk(0, 8'h00, 1'b0, 1'b0, 1'b1, "reset_in_down");
        chk("reset_in_down.exact", led_a, 8'h00);
        rstn_a  = 1'b1;
        cur_led = 8'h00;

        // UP with pos=2: head constant, trail (if built) lit 1 cycle in 4.
        step(0, 8'h01, 1'b0, 1'b1);
        step(0, 8'h02, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) edge_chk(0, 8'h02, 1'b0, 1'b0, 1'b1, "quiet");
        for (int i = 0; i < 4; i++) begin
            if (i != 0) begin
                @(posedge clk);
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
            t_exp = (TRAIL && (i == 0)) ? 8'h06 : 8'h04;
            chk("pos2_exact", led_a, t_exp);
        end

        // Instance B, PAUSE_STEPS=0: ...40,80,40 with turnaround on 80->40.
        rstn_b  = 1'b1;
        cur_led = 8'h00;
        for (int i = 0; i < 8; i++) step(1, up_seq[i], 1'b0, 1'b1);
        step(1, 8'h40, 1'b1, 1'b1);
        step(1, 8'h20, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
